// File: rtl/uart_bus_pkg.sv
// Shared types and protocol constants for the UART-to-bus command bridge.
package uart_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WDATA   = 3'd2,
    S_BUS_WR  = 3'd3,
    S_BUS_RD  = 3'd4,
    S_RESP    = 3'd5,
    S_TX_BUSY = 3'd6
  } uart_bus_state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

endpackage

// File: rtl/uart_bus_master_if.sv
// UART byte handshakes plus peripheral bus signals seen by the bridge.
// RX: a byte is offered while RX_DATA_VALID=1 and consumed by a one-cycle
// RX_DATA_READ pulse; TX: a one-cycle TX_DATA_VALID pulse is issued only while
// TX_IDLE=1; bus: WRSTB/RDSTB are single-cycle strobes qualified by ADDR/DATA_O.
interface uart_bus_master_if;
  logic [7:0]  RX_DATA;
  logic        RX_DATA_VALID;
  logic        RX_DATA_READ;
  logic [7:0]  TX_DATA;
  logic        TX_DATA_VALID;
  logic        TX_IDLE;
  logic [31:0] ADDR;
  logic [31:0] DATA_O;
  logic [31:0] DATA_I;
  logic        WRSTB;
  logic        RDSTB;

  modport master (
    input  RX_DATA, RX_DATA_VALID, TX_IDLE, DATA_I,
    output RX_DATA_READ, TX_DATA, TX_DATA_VALID, ADDR, DATA_O, WRSTB, RDSTB
  );

  modport slave (
    output RX_DATA, RX_DATA_VALID, TX_IDLE, DATA_I,
    input  RX_DATA_READ, TX_DATA, TX_DATA_VALID, ADDR, DATA_O, WRSTB, RDSTB
  );
endinterface

// File: rtl/uart_resp_sender.sv
// Serialises a 1..4 byte response, LSB first, toward UART_TX; each byte waits
// for TX_IDLE to drop and rise again before the next is offered.
module uart_resp_sender
  import uart_bus_pkg::*;
(
  input  logic            ACLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [31:0]     word_i,
  input  logic [2:0]      count_i,
  input  logic            tx_idle,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  output logic            done,
  output uart_bus_state_t dbg_state
);

  uart_bus_state_t state;
  logic [31:0]     word_q;
  logic [2:0]      remaining;
  logic            saw_low;

  assign dbg_state = state;

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      word_q    <= 32'h0;
      remaining <= 3'd0;
      saw_low   <= 1'b0;
      tx_data   <= 8'h0;
      tx_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            word_q    <= word_i;
            remaining <= count_i;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_idle) begin
            tx_data   <= word_q[7:0];
            tx_valid  <= 1'b1;
            word_q    <= {8'h00, word_q[31:8]};
            remaining <= remaining - 3'd1;
            saw_low   <= 1'b0;
            state     <= S_TX_BUSY;
          end
        end
        S_TX_BUSY: begin
          // TX_IDLE is still high in the pulse cycle; require a low phase first.
          if (!tx_idle) begin
            saw_low <= 1'b1;
          end else if (saw_low) begin
            if (remaining == 3'd0) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_RESP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART command bridge: 'W' addr[4] data[4] -> bus write + 'K';
// 'R' addr[4] -> bus read + 4 data bytes; anything else -> '?'.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             ACLK,
  input  logic             RESET,
  uart_bus_master_if.master bus,
  output logic             BUSY,
  output uart_bus_state_t  dbg_state,
  output uart_bus_state_t  dbg_resp_state
);

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);
  localparam logic [2:0]  LAT = 3'(READ_LATENCY);

  uart_bus_state_t state;
  logic            is_wr;
  logic [1:0]      idx;
  logic            rx_read;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            wrstb_q;
  logic            rdstb_q;
  logic [2:0]      lat_cnt;
  logic [31:0]     gap_cnt;
  logic            snd_start;
  logic [31:0]     snd_word;
  logic [2:0]      snd_count;
  logic            snd_done;
  logic            capture;
  logic            in_cmd;
  logic            timeout;

  assign in_cmd  = (state == S_ADDR) || (state == S_WDATA);
  // The registered RX_DATA_READ masks the byte still shown during its own consume cycle.
  assign capture = bus.RX_DATA_VALID && !rx_read && (in_cmd || (state == S_IDLE));
  assign timeout = (TIMEOUT_CYCLES != 0) && (gap_cnt >= TMO);

  assign bus.RX_DATA_READ = rx_read;
  assign bus.ADDR         = addr_q;
  assign bus.DATA_O       = wdata_q;
  assign bus.WRSTB        = wrstb_q;
  assign bus.RDSTB        = rdstb_q;
  assign BUSY             = (state != S_IDLE);
  assign dbg_state        = state;

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      is_wr     <= 1'b0;
      idx       <= 2'd0;
      rx_read   <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wrstb_q   <= 1'b0;
      rdstb_q   <= 1'b0;
      lat_cnt   <= 3'd0;
      gap_cnt   <= 32'h0;
      snd_start <= 1'b0;
      snd_word  <= 32'h0;
      snd_count <= 3'd0;
    end else begin
      rx_read   <= capture;
      wrstb_q   <= 1'b0;
      rdstb_q   <= 1'b0;
      snd_start <= 1'b0;
      if (capture || !in_cmd) gap_cnt <= 32'h0;
      else                    gap_cnt <= gap_cnt + 32'd1;

      case (state)
        S_IDLE: begin
          if (capture) begin
            idx <= 2'd0;
            if (bus.RX_DATA == CMD_WR || bus.RX_DATA == CMD_RD) begin
              is_wr <= (bus.RX_DATA == CMD_WR);
              state <= S_ADDR;
            end else begin
              snd_word  <= {24'h0, RSP_ERR};
              snd_count <= 3'd1;
              snd_start <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (capture) begin
            addr_q[{idx, 3'b000} +: 8] <= bus.RX_DATA;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (is_wr) begin
                state <= S_WDATA;
              end else begin
                rdstb_q <= 1'b1;
                lat_cnt <= 3'd0;
                state   <= S_BUS_RD;
              end
            end
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_WDATA: begin
          if (capture) begin
            wdata_q[{idx, 3'b000} +: 8] <= bus.RX_DATA;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              wrstb_q <= 1'b1;
              state   <= S_BUS_WR;
            end
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_BUS_WR: begin
          snd_word  <= {24'h0, RSP_ACK};
          snd_count <= 3'd1;
          snd_start <= 1'b1;
          state     <= S_RESP;
        end
        S_BUS_RD: begin
          // lat_cnt is 0 in the strobe cycle, so DATA_I is taken READ_LATENCY cycles later.
          if (lat_cnt == LAT) begin
            snd_word  <= bus.DATA_I;
            snd_count <= 3'd4;
            snd_start <= 1'b1;
            state     <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_RESP: begin
          if (snd_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_resp_sender u_sender (
    .ACLK      (ACLK),
    .RESET     (RESET),
    .start     (snd_start),
    .word_i    (snd_word),
    .count_i   (snd_count),
    .tx_idle   (bus.TX_IDLE),
    .tx_data   (bus.TX_DATA),
    .tx_valid  (bus.TX_DATA_VALID),
    .done      (snd_done),
    .dbg_state (dbg_resp_state)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: vector table of complete commands plus
// hand sequences for timeout, slow RX release, queued RX and mid-command reset.
module tb_uart_bus_master;
  import uart_bus_pkg::*;

  logic            ACLK;
  logic            RESET;
  logic            BUSY;
  uart_bus_state_t dbg_state;
  uart_bus_state_t dbg_resp_state;

  uart_bus_master_if bus ();

  uart_bus_master #(.READ_LATENCY(1), .TIMEOUT_CYCLES(100)) dut (
    .ACLK           (ACLK),
    .RESET          (RESET),
    .bus            (bus),
    .BUSY           (BUSY),
    .dbg_state      (dbg_state),
    .dbg_resp_state (dbg_resp_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] rd_word = 32'h0;

  int wr_cnt = 0, rd_cnt = 0, rx_read_cnt = 0;
  int both_err = 0, long_err = 0, bad_read = 0, txv_long = 0, txv_bad = 0;
  logic [31:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
  logic prev_wr = 0, prev_rd = 0, prev_txv = 0, prev_idle = 1;
  uart_bus_state_t prev_state = S_IDLE;
  int tx_idle_cnt = 0;
  logic rd_pipe = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- bus / UART monitor ----------------
  always @(negedge ACLK) begin
    if (!RESET) begin
      if (bus.WRSTB) begin wr_cnt++; wr_addr = bus.ADDR; wr_data = bus.DATA_O; end
      if (bus.RDSTB) begin rd_cnt++; rd_addr = bus.ADDR; end
      if (bus.WRSTB && bus.RDSTB) both_err++;
      if ((bus.WRSTB && prev_wr) || (bus.RDSTB && prev_rd)) long_err++;
      if (bus.RX_DATA_READ) begin
        rx_read_cnt++;
        if (!(prev_state inside {S_IDLE, S_ADDR, S_WDATA})) bad_read++;
      end
    end
    prev_wr    = bus.WRSTB;
    prev_rd    = bus.RDSTB;
    prev_state = dbg_state;
  end

  // ---------------- UART_TX model: busy for 4 cycles per byte ----------------
  always @(negedge ACLK) begin
    if (RESET) begin
      tx_idle_cnt = 0;
      bus.TX_IDLE = 1'b1;
      prev_txv    = 1'b0;
    end else begin
      if (tx_idle_cnt > 0) begin
        tx_idle_cnt--;
        if (tx_idle_cnt == 0) bus.TX_IDLE = 1'b1;
      end
      if (bus.TX_DATA_VALID) begin
        tx_q.push_back(bus.TX_DATA);
        if (prev_txv) txv_long++;
        if (!prev_idle) txv_bad++;
        bus.TX_IDLE = 1'b0;
        tx_idle_cnt = 4;
      end
      prev_txv = bus.TX_DATA_VALID;
    end
    prev_idle = bus.TX_IDLE;
  end

  // ---------------- slave model: DATA_I valid only READ_LATENCY=1 after RDSTB ----------------
  always @(negedge ACLK) begin
    if (RESET) begin
      rd_pipe    = 1'b0;
      bus.DATA_I = 32'hDEAD_BEEF;
    end else begin
      bus.DATA_I = rd_pipe ? rd_word : 32'hDEAD_BEEF;
      rd_pipe    = bus.RDSTB;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit slow);
    int n;
    bus.RX_DATA       = b;
    bus.RX_DATA_VALID = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!bus.RX_DATA_READ && n < 400);
    check("rx_consume", 32'(bus.RX_DATA_READ), 32'd1);
    if (slow) @(negedge ACLK);
    bus.RX_DATA_VALID = 1'b0;
  endtask

  task automatic send_cmd(input logic [71:0] cmd, input int n, input bit slow);
    for (int i = 0; i < n; i++) send_byte(cmd[8*i +: 8], slow);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY && n < 2000) begin
      @(negedge ACLK);
      n++;
    end
    check(name, 32'(BUSY), 32'd0);
    repeat (2) @(negedge ACLK);
  endtask

  task automatic check_tx(input string name);
    check({name, "_tx_count"}, 32'(tx_q.size()), 32'(exp_q.size()));
    while (tx_q.size() > 0 && exp_q.size() > 0)
      check({name, "_tx_byte"}, 32'(tx_q.pop_front()), 32'(exp_q.pop_front()));
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_ctl"}, 32'({bus.RX_DATA_READ, bus.TX_DATA_VALID, bus.WRSTB, bus.RDSTB, BUSY}), 32'd0);
    check({name, "_txd"}, 32'(bus.TX_DATA), 32'd0);
    check({name, "_addr"}, bus.ADDR, 32'd0);
    check({name, "_dout"}, bus.DATA_O, 32'd0);
  endtask

  function automatic logic [71:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8);
    return {b8, b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [71:0] cmd;
    logic [3:0]  n;
    logic [31:0] rd_word;
    logic [1:0]  exp_wr;
    logic [1:0]  exp_rd;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_tx;    // LSB byte goes out first
    logic [2:0]  exp_ntx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int wr0, rd0, rr0;
    bus.RX_DATA       = 8'h00;
    bus.RX_DATA_VALID = 1'b0;
    RESET = 1'b1;
    repeat (5) @(negedge ACLK);
    check_zero_outputs("reset");
    RESET = 1'b0;
    repeat (2) @(negedge ACLK);

    vecs[0] = '{cmd: mk(8'h57, 8'h00, 8'h00, 8'h00, 8'h60, 8'h41, 8'h00, 8'h00, 8'h00), n: 4'd9,
                rd_word: 32'h0, exp_wr: 2'd1, exp_rd: 2'd0, exp_addr: 32'h6000_0000,
                exp_data: 32'h0000_0041, exp_tx: 32'h0000_004B, exp_ntx: 3'd1};
    vecs[1] = '{cmd: mk(8'h52, 8'h01, 8'h00, 8'h00, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00), n: 4'd5,
                rd_word: 32'hA1B2_C3D4, exp_wr: 2'd0, exp_rd: 2'd1, exp_addr: 32'h6000_0001,
                exp_data: 32'h0, exp_tx: 32'hA1B2_C3D4, exp_ntx: 3'd4};
    vecs[2] = '{cmd: mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), n: 4'd1,
                rd_word: 32'h0, exp_wr: 2'd0, exp_rd: 2'd0, exp_addr: 32'h0,
                exp_data: 32'h0, exp_tx: 32'h0000_003F, exp_ntx: 3'd1};
    vecs[3] = '{cmd: mk(8'h52, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00), n: 4'd5,
                rd_word: 32'h0BAD_F00D, exp_wr: 2'd0, exp_rd: 2'd1, exp_addr: 32'h1234_5678,
                exp_data: 32'h0, exp_tx: 32'h0BAD_F00D, exp_ntx: 3'd4};
    vecs[4] = '{cmd: mk(8'h57, 8'h04, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE), n: 4'd9,
                rd_word: 32'h0, exp_wr: 2'd1, exp_rd: 2'd0, exp_addr: 32'h8000_0004,
                exp_data: 32'hDEAD_BEEF, exp_tx: 32'h0000_004B, exp_ntx: 3'd1};
    vecs[5] = '{cmd: mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), n: 4'd1,
                rd_word: 32'h0, exp_wr: 2'd0, exp_rd: 2'd0, exp_addr: 32'h0,
                exp_data: 32'h0, exp_tx: 32'h0000_003F, exp_ntx: 3'd1};

    for (int v = 0; v < 6; v++) begin
      wr0 = wr_cnt; rd0 = rd_cnt; rr0 = rx_read_cnt;
      rd_word = vecs[v].rd_word;
      tx_q.delete();
      for (int i = 0; i < int'(vecs[v].exp_ntx); i++) exp_q.push_back(vecs[v].exp_tx[8*i +: 8]);
      send_cmd(vecs[v].cmd, int'(vecs[v].n), 1'b0);
      wait_idle($sformatf("v%0d_busy", v));
      check($sformatf("v%0d_wr_cnt", v), 32'(wr_cnt - wr0), 32'(vecs[v].exp_wr));
      check($sformatf("v%0d_rd_cnt", v), 32'(rd_cnt - rd0), 32'(vecs[v].exp_rd));
      check($sformatf("v%0d_rx_reads", v), 32'(rx_read_cnt - rr0), 32'(vecs[v].n));
      if (vecs[v].exp_wr != 0) begin
        check($sformatf("v%0d_wr_addr", v), wr_addr, vecs[v].exp_addr);
        check($sformatf("v%0d_wr_data", v), wr_data, vecs[v].exp_data);
      end
      if (vecs[v].exp_rd != 0) check($sformatf("v%0d_rd_addr", v), rd_addr, vecs[v].exp_addr);
      check_tx($sformatf("v%0d", v));
    end

    // Timeout: partial write stalls past 100 cycles, then a fresh full write.
    wr0 = wr_cnt; rd0 = rd_cnt;
    send_cmd(mk(8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 3, 1'b0);
    repeat (150) @(negedge ACLK);
    check("tmo_busy", 32'(BUSY), 32'd0);
    check("tmo_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
    check("tmo_tx", 32'(tx_q.size()), 32'd0);
    check("tmo_addr_kept", bus.ADDR, 32'h8000_0000);
    check("tmo_data_kept", bus.DATA_O, 32'hDEAD_BEEF);
    exp_q.push_back(8'h4B);
    send_cmd(mk(8'h57, 8'h10, 8'h00, 8'h00, 8'h70, 8'h11, 8'h22, 8'h33, 8'h44), 9, 1'b0);
    wait_idle("tmo_wr_busy");
    check("tmo_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    check("tmo_wr_addr", wr_addr, 32'h7000_0010);
    check("tmo_wr_data", wr_data, 32'h4433_2211);
    check_tx("tmo_wr");

    // Stall shorter than the timeout must not abort.
    rd0 = rd_cnt;
    rd_word = 32'h0102_0304;
    send_byte(8'h52, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (60) @(negedge ACLK);
    check("stall_busy", 32'(BUSY), 32'd1);
    send_cmd(mk(8'h00, 8'h00, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 3, 1'b0);
    wait_idle("stall_idle");
    check("stall_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
    check("stall_rd_addr", rd_addr, 32'h9000_0000);
    exp_q.push_back(8'h04); exp_q.push_back(8'h03); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
    check_tx("stall");

    // Slow RX release: VALID stays high through the READ cycle.
    wr0 = wr_cnt; rr0 = rx_read_cnt;
    exp_q.push_back(8'h4B);
    send_cmd(mk(8'h57, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04), 9, 1'b1);
    wait_idle("slow_busy");
    check("slow_rx_reads", 32'(rx_read_cnt - rr0), 32'd9);
    check("slow_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    check("slow_wr_addr", wr_addr, 32'hDDCC_BBAA);
    check("slow_wr_data", wr_data, 32'h0403_0201);
    check_tx("slow");

    // Next byte offered while the read is still responding must wait its turn.
    rd_word = 32'h5566_7788;
    send_cmd(mk(8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 5, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_idle("queue_busy");
    exp_q.push_back(8'h88); exp_q.push_back(8'h77); exp_q.push_back(8'h66); exp_q.push_back(8'h55);
    exp_q.push_back(8'h3F);
    check_tx("queue");

    // Reset during the read-latency wait.
    send_cmd(mk(8'h52, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 5, 1'b0);
    @(negedge ACLK);
    check("rst_rd_state", 32'(dbg_state), 32'(S_BUS_RD));
    RESET = 1'b1;
    #1;
    check_zero_outputs("rst_rd");
    @(negedge ACLK);
    RESET = 1'b0;
    tx_q.delete();
    repeat (30) @(negedge ACLK);
    check("rst_rd_no_tx", 32'(tx_q.size()), 32'd0);

    // Reset during S_TX_BUSY of a read response.
    begin
      int n;
      send_cmd(mk(8'h52, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 5, 1'b0);
      n = 0;
      while (tx_q.size() < 2 && n < 500) begin
        @(negedge ACLK);
        n++;
      end
      check("rst_tx_state", 32'(dbg_resp_state), 32'(S_TX_BUSY));
    end
    RESET = 1'b1;
    #1;
    check_zero_outputs("rst_tx");
    @(negedge ACLK);
    RESET = 1'b0;
    tx_q.delete();
    repeat (30) @(negedge ACLK);
    check("rst_tx_no_tx", 32'(tx_q.size()), 32'd0);
    exp_q.push_back(8'h3F);
    send_byte(8'h00, 1'b0);
    wait_idle("post_rst_busy");
    check_tx("post_rst");

    check("strobe_overlap", 32'(both_err), 32'd0);
    check("strobe_length", 32'(long_err), 32'd0);
    check("rx_read_state", 32'(bad_read), 32'd0);
    check("txv_length", 32'(txv_long), 32'd0);
    check("txv_while_busy", 32'(txv_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
